// File: rtl/sprite_blitter_pkg.sv
// Shared constants, state encoding and the default sprite image for the sprite blitter.
// Optional feature macro used by the blitter: SPRITE_BLITTER_TRANSPARENCY_EN.
package sprite_blitter_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
  localparam int X_W = 9;
  localparam int Y_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_t;

  // Row-major texel image: every 11th word is black, the rest cycle through colours 1..7.
  function automatic logic [COLOUR_W-1:0] texel_default(input int a);
    if (a % 11 == 0) return COLOUR_BLACK;
    return COLOUR_W'((a % 7) + 1);
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous DEPTH x 3-bit sprite ROM; data appears one cycle after the address.
// Contents are elaborated from sprite_blitter_pkg::texel_default.
module sprite_rom
  import sprite_blitter_pkg::*;
#(
  parameter int DEPTH  = 400,
  parameter int ADDR_W = 9
) (
  input  logic                i_clk,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [COLOUR_W-1:0] o_data
);

  function automatic logic [DEPTH*COLOUR_W-1:0] build_image();
    logic [DEPTH*COLOUR_W-1:0] img;
    img = '0;
    for (int i = 0; i < DEPTH; i++) begin
      img[i*COLOUR_W +: COLOUR_W] = texel_default(i);
    end
    return img;
  endfunction

  localparam logic [DEPTH*COLOUR_W-1:0] IMAGE = build_image();

  logic [COLOUR_W-1:0] r_data;

  always_ff @(posedge i_clk) begin
    r_data <= IMAGE[int'(i_addr)*COLOUR_W +: COLOUR_W];
  end

  assign o_data = r_data;

endmodule

// File: rtl/sprite_blitter.sv
// Walks a SPR_W x SPR_H box, one ROM texel per cycle, emitting clipped (x, y, colour, plot) pixels.
// Build option: define SPRITE_BLITTER_TRANSPARENCY_EN to skip plotting black non-blackout texels.
module sprite_blitter #(
  parameter int SPR_W    = 20,
  parameter int SPR_H    = 20,
  parameter int SCREEN_W = sprite_blitter_pkg::SCREEN_W,
  parameter int SCREEN_H = sprite_blitter_pkg::SCREEN_H
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       blackout,
  input  logic [8:0] x_pos_init,
  input  logic [7:0] y_pos_init,
  output logic       busy,
  output logic       plot,
  output logic [8:0] x_pos_final,
  output logic [7:0] y_pos_final,
  output logic [2:0] colour,
  output logic       done
);

  import sprite_blitter_pkg::*;

  localparam int DEPTH  = SPR_W * SPR_H;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t r_state, w_next;
  logic   w_issue;
  logic   w_last;

  logic [4:0]          r_col, r_row;
  logic [ADDR_W-1:0]   r_addr;
  logic [X_W-1:0]      r_x_org;
  logic [Y_W-1:0]      r_y_org;
  logic                r_blk;

  logic                r_s1_vld;
  logic [X_W:0]        r_s1_x;
  logic [Y_W:0]        r_s1_y;
  logic [COLOUR_W-1:0] w_rom_data;
  logic                w_on_screen;
  logic                w_transparent;

  logic                r_plot;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [COLOUR_W-1:0] r_colour;

  assign w_last = (r_col == 5'(SPR_W - 1)) && (r_row == 5'(SPR_H - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // DRAIN holds until the ROM/coordinate stage has emptied into the output register.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN: begin
        w_issue = 1'b1;
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: if (!r_s1_vld) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col   <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_x_org <= '0;
      r_y_org <= '0;
      r_blk   <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_col   <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_x_org <= x_pos_init;
      r_y_org <= y_pos_init;
      r_blk   <= blackout;
    end else if (w_issue) begin
      r_addr <= r_addr + 1'b1;
      if (r_col == 5'(SPR_W - 1)) begin
        r_col <= '0;
        r_row <= r_row + 5'd1;
      end else begin
        r_col <= r_col + 5'd1;
      end
    end
  end

  sprite_rom #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .i_clk  (clk),
    .i_addr (r_addr),
    .o_data (w_rom_data)
  );

  // Coordinates travel alongside the ROM read so they line up with its data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_vld <= 1'b0;
      r_s1_x   <= '0;
      r_s1_y   <= '0;
    end else begin
      r_s1_vld <= w_issue;
      if (w_issue) begin
        r_s1_x <= {1'b0, r_x_org} + {5'd0, r_col};
        r_s1_y <= {1'b0, r_y_org} + {4'd0, r_row};
      end
    end
  end

  assign w_on_screen = (r_s1_x < 10'(SCREEN_W)) && (r_s1_y < 9'(SCREEN_H));

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  assign w_transparent = !r_blk && (w_rom_data == COLOUR_BLACK);
`else
  assign w_transparent = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_plot   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
    end else begin
      r_plot <= r_s1_vld && w_on_screen && !w_transparent;
      if (r_s1_vld) begin
        r_x      <= r_s1_x[X_W-1:0];
        r_y      <= r_s1_y[Y_W-1:0];
        r_colour <= r_blk ? COLOUR_BLACK : w_rom_data;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign plot        = r_plot;
  assign x_pos_final = r_x;
  assign y_pos_final = r_y;
  assign colour      = r_colour;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: stimulus pushes expected pixels/done cycles, a negedge monitor pops and compares.
module tb_sprite_blitter;

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif
  localparam int FULL_CNT = TRANSP ? 363 : 400;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       blackout = 1'b0;
  logic [8:0] x_pos_init = '0;
  logic [7:0] y_pos_init = '0;
  logic       busy, plot, done;
  logic [8:0] x_pos_final;
  logic [7:0] y_pos_final;
  logic [2:0] colour;

  sprite_blitter dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .blackout    (blackout),
    .x_pos_init  (x_pos_init),
    .y_pos_init  (y_pos_init),
    .busy        (busy),
    .plot        (plot),
    .x_pos_final (x_pos_final),
    .y_pos_final (y_pos_final),
    .colour      (colour),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } pix_t;

  pix_t exp_pix[$];
  int   exp_done[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   plot_cnt = 0;
  pix_t mon_p;
  int   mon_t;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int tex(input int a);
    if (a % 11 == 0) return 0;
    return (a % 7) + 1;
  endfunction

  always @(negedge clk) begin
    if (resetn) begin
      if (plot) begin
        plot_cnt++;
        if (exp_pix.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_plot: got plot at cycle %0d (%0d,%0d), expected none", cyc, x_pos_final, y_pos_final);
        end else begin
          mon_p = exp_pix.pop_front();
          chk("pix_x", int'(x_pos_final), mon_p.x);
          chk("pix_y", int'(y_pos_final), mon_p.y);
          chk("pix_colour", int'(colour), mon_p.c);
          chk("pix_cycle", cyc, mon_p.t);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          mon_t = exp_done.pop_front();
          chk("done_cycle", cyc, mon_t);
        end
      end
    end
  end

  task automatic issue(input int ox, input int oy, input bit blk, output int s);
    int x, y, c, slot;
    @(negedge clk);
    x_pos_init = 9'(ox);
    y_pos_init = 8'(oy);
    blackout   = blk;
    start      = 1'b1;
    s          = cyc + 1;
    plot_cnt   = 0;
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 20; k++) begin
        slot = r * 20 + k;
        x = ox + k;
        y = oy + r;
        c = blk ? 0 : tex(slot);
        if (x < 320 && y < 240 && !(TRANSP && !blk && c == 0))
          exp_pix.push_back('{x: x, y: y, c: c, t: s + 2 + slot});
      end
    end
    exp_done.push_back(s + 402);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_idle(input string name, input int exp_n);
    int k = 0;
    while ((exp_pix.size() != 0 || exp_done.size() != 0 || busy) && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 1000) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d pixels / %0d dones outstanding, expected 0", name, exp_pix.size(), exp_done.size());
    end
    chk({name, "_plot_count"}, plot_cnt, exp_n);
  endtask

  initial begin
    int s;
    int k;

    #12;
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_x", int'(x_pos_final), 0);
    chk("rst_y", int'(y_pos_final), 0);
    chk("rst_colour", int'(colour), 0);
    @(negedge clk);
    resetn = 1'b1;

    // Nominal walk: first pixel (146,220), last (165,239)
    issue(146, 220, 1'b0, s);
    wait_idle("walk", FULL_CNT);
    chk("walk_last_x", int'(x_pos_final), 165);
    chk("walk_last_y", int'(y_pos_final), 239);

    // Blackout: all colour 0, every in-screen pixel plotted
    issue(146, 220, 1'b1, s);
    wait_idle("blackout", 400);

    // Clipping at right and bottom edges
    issue(310, 230, 1'b1, s);
    wait_idle("clip", 100);
    chk("clip_last_x", int'(x_pos_final), 329 % 512);
    chk("clip_last_y", int'(y_pos_final), 249 % 256);

    // Reset mid-walk after 57 plots
    issue(20, 10, 1'b0, s);
    k = 0;
    while (plot_cnt < 57 && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("mid_plot_count", plot_cnt, 57);
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_plot", int'(plot), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    exp_pix.delete();
    exp_done.delete();
    @(negedge clk);
    resetn = 1'b1;
    issue(20, 10, 1'b0, s);
    wait_idle("after_reset", FULL_CNT);

    // Start pulses while busy and in the DONE cycle are ignored
    issue(100, 50, 1'b0, s);
    while (cyc < s + 100) @(negedge clk);
    x_pos_init = 9'd7;
    y_pos_init = 8'd7;
    blackout   = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 402) @(negedge clk);
    chk("ignore_done_cycle", int'(done), 1);
    x_pos_init = 9'd9;
    y_pos_init = 8'd9;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ignore", FULL_CNT);
    repeat (5) @(negedge clk);
    #1;
    chk("ignore_idle_busy", int'(busy), 0);
    chk("ignore_extra_pixels", exp_pix.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
